// File: rtl/tomasula_types.sv
// Shared types and defaults for the Tomasulo core's common data bus.
package tomasula_types;

  localparam int CDB_NUM_SRC = 8;
  localparam int CDB_NUM_BUS = 1;
  localparam int CDB_TAG_W   = 3;
  localparam int CDB_DATA_W  = 32;
  localparam int CDB_SRC_W   = $clog2(CDB_NUM_SRC);

  // Default-width view of one broadcast; the arbiter builds its own from its parameters.
  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
    logic [CDB_SRC_W-1:0]  src;
  } cdb_entry_t;

  function automatic int wrap_add(input int base, input int step, input int n);
    return (base + step) % n;
  endfunction

endpackage

// File: rtl/cdb_slot.sv
// One-entry holding register for a functional unit result awaiting the CDB.
module cdb_slot #(
  parameter int W = 35
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         flush,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         full,
  output logic [W-1:0] q
);

  // A load on the same edge as a clear wins, so a granted slot can be refilled without a bubble.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full <= 1'b0;
      q    <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      q    <= d;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus: per-unit holding slots, round-robin selection of up to NUM_BUS slots,
// and registered broadcast lanes snooped by reservation stations, regfile and ROB.
module cdb_arbiter
  import tomasula_types::*;
#(
  parameter int NUM_SRC = CDB_NUM_SRC,
  parameter int NUM_BUS = CDB_NUM_BUS,
  parameter int TAG_W   = CDB_TAG_W,
  parameter int DATA_W  = CDB_DATA_W,
  parameter int SRC_W   = $clog2(NUM_SRC),
  parameter int CNT_W   = $clog2(NUM_SRC + 1)
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              flush,
  input  logic [NUM_SRC-1:0]                src_valid,
  output logic [NUM_SRC-1:0]                src_ready,
  input  logic [NUM_SRC-1:0][TAG_W-1:0]     src_tag,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]    src_data,
  output logic [NUM_BUS-1:0]                cdb_valid,
  output logic [NUM_BUS-1:0][TAG_W-1:0]     cdb_tag,
  output logic [NUM_BUS-1:0][DATA_W-1:0]    cdb_data,
  output logic [NUM_BUS-1:0][SRC_W-1:0]     cdb_src,
  output logic [CNT_W-1:0]                  pending_cnt
);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t                          slot_q [NUM_SRC];
  logic [NUM_SRC-1:0]              slot_full;
  logic [NUM_SRC-1:0]              grant;
  logic [NUM_SRC-1:0]              load;
  logic [NUM_SRC-1:0]              full_nxt;
  logic [NUM_SRC-1:0]              avail;
  logic [NUM_BUS-1:0]              lane_hit;
  logic [NUM_BUS-1:0][SRC_W-1:0]   lane_sel;
  logic [SRC_W-1:0]                last_sel;
  logic [SRC_W-1:0]                rr_ptr;
  logic [SRC_W-1:0]                rr_nxt;
  logic [CNT_W-1:0]                cnt_nxt;
  int                              idx;

  // Handshake: a unit's result transfers at an edge where src_valid and src_ready are both high;
  // src_ready depends only on slot state, grant and flush, never on src_valid.
  assign src_ready = flush ? '0 : (~slot_full | grant);
  assign load      = src_valid & src_ready;
  assign full_nxt  = flush ? '0 : ((slot_full & ~grant) | load);

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
    entry_t slot_d;
    assign slot_d.tag  = src_tag[i];
    assign slot_d.data = src_data[i];

    cdb_slot #(.W($bits(entry_t))) u_slot (
      .clk   (clk),
      .rstn  (rstn),
      .flush (flush),
      .load  (load[i]),
      .clear (grant[i]),
      .d     (slot_d),
      .full  (slot_full[i]),
      .q     (slot_q[i])
    );
  end

  // Each lane takes the next still-unclaimed full slot in scan order starting at rr_ptr.
  always_comb begin
    avail    = slot_full;
    grant    = '0;
    lane_hit = '0;
    lane_sel = '0;
    last_sel = rr_ptr;
    idx      = 0;
    for (int b = 0; b < NUM_BUS; b++) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        idx = wrap_add(int'(rr_ptr), k, NUM_SRC);
        if (!lane_hit[b] && avail[idx]) begin
          lane_hit[b] = 1'b1;
          lane_sel[b] = SRC_W'(idx);
          avail[idx]  = 1'b0;
          grant[idx]  = 1'b1;
          last_sel    = SRC_W'(idx);
        end
      end
    end
  end

  assign rr_nxt = SRC_W'(wrap_add(int'(last_sel), 1, NUM_SRC));

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cnt_nxt = cnt_nxt + CNT_W'(full_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cdb_valid   <= '0;
      cdb_tag     <= '0;
      cdb_data    <= '0;
      cdb_src     <= '0;
      rr_ptr      <= '0;
      pending_cnt <= '0;
    end else begin
      pending_cnt <= cnt_nxt;
      if (flush) begin
        cdb_valid <= '0;
      end else begin
        cdb_valid <= lane_hit;
        if (|lane_hit) begin
          rr_ptr <= rr_nxt;
        end
        for (int b = 0; b < NUM_BUS; b++) begin
          if (lane_hit[b]) begin
            cdb_tag[b]  <= slot_q[lane_sel[b]].tag;
            cdb_data[b] <= slot_q[lane_sel[b]].data;
            cdb_src[b]  <= lane_sel[b];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a single-lane instance driven from a vector table plus
// hand sequences, and a dual-lane instance sharing the same stimulus.
module tb_cdb_arbiter;

  logic                clk = 1'b0;
  logic                rstn;
  logic                flush;
  logic [7:0]          src_valid;
  logic [7:0][2:0]     src_tag;
  logic [7:0][31:0]    src_data;

  logic [7:0]          ready1;
  logic [0:0]          cv1;
  logic [0:0][2:0]     tag1;
  logic [0:0][31:0]    data1;
  logic [0:0][2:0]     src1;
  logic [3:0]          cnt1;

  logic [7:0]          ready2;
  logic [1:0]          cv2;
  logic [1:0][2:0]     tag2;
  logic [1:0][31:0]    data2;
  logic [1:0][2:0]     src2;
  logic [3:0]          cnt2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_SRC(8), .NUM_BUS(1), .TAG_W(3), .DATA_W(32)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .src_valid(src_valid), .src_ready(ready1), .src_tag(src_tag), .src_data(src_data),
    .cdb_valid(cv1), .cdb_tag(tag1), .cdb_data(data1), .cdb_src(src1), .pending_cnt(cnt1)
  );

  cdb_arbiter #(.NUM_SRC(8), .NUM_BUS(2), .TAG_W(3), .DATA_W(32)) dut2 (
    .clk(clk), .rstn(rstn), .flush(flush),
    .src_valid(src_valid), .src_ready(ready2), .src_tag(src_tag), .src_data(src_data),
    .cdb_valid(cv2), .cdb_tag(tag2), .cdb_data(data2), .cdb_src(src2), .pending_cnt(cnt2)
  );

  typedef struct {
    logic [7:0] v;
    logic       fl;
    logic [2:0] t;
    logic [7:0] rdy;
    logic       cv;
    logic [2:0] src;
    logic [2:0] tag;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl [13];

  function automatic logic [31:0] data_of(input int u, input logic [2:0] t);
    return 32'hC0DE_0000 | (32'(u) << 8) | 32'(t);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic [7:0] v, input logic fl, input logic [2:0] t);
    src_valid = v;
    flush     = fl;
    for (int i = 0; i < 8; i++) begin
      src_tag[i]  = t;
      src_data[i] = data_of(i, t);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    set_in(8'h00, 1'b0, 3'd0);
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //                 v      fl    t     rdy    cv    src   tag   cnt
    tbl[0]  = '{8'h20, 1'b0, 3'd3, 8'hFF, 1'b0, 3'd0, 3'd0, 4'd1};
    tbl[1]  = '{8'h00, 1'b0, 3'd0, 8'hFF, 1'b1, 3'd5, 3'd3, 4'd0};
    tbl[2]  = '{8'h00, 1'b0, 3'd0, 8'hFF, 1'b0, 3'd5, 3'd3, 4'd0};
    tbl[3]  = '{8'h06, 1'b0, 3'd2, 8'hFF, 1'b0, 3'd5, 3'd3, 4'd2};
    tbl[4]  = '{8'h01, 1'b0, 3'd5, 8'hFB, 1'b1, 3'd1, 3'd2, 4'd2};
    tbl[5]  = '{8'h00, 1'b0, 3'd0, 8'hFE, 1'b1, 3'd2, 3'd2, 4'd1};
    tbl[6]  = '{8'h00, 1'b0, 3'd0, 8'hFF, 1'b1, 3'd0, 3'd5, 4'd0};
    tbl[7]  = '{8'h81, 1'b0, 3'd6, 8'hFF, 1'b0, 3'd0, 3'd5, 4'd2};
    tbl[8]  = '{8'h00, 1'b1, 3'd0, 8'h00, 1'b0, 3'd0, 3'd5, 4'd0};
    tbl[9]  = '{8'h00, 1'b0, 3'd0, 8'hFF, 1'b0, 3'd0, 3'd5, 4'd0};
    tbl[10] = '{8'h02, 1'b0, 3'd7, 8'hFF, 1'b0, 3'd0, 3'd5, 4'd1};
    tbl[11] = '{8'h02, 1'b0, 3'd1, 8'hFF, 1'b1, 3'd1, 3'd7, 4'd1};
    tbl[12] = '{8'h00, 1'b0, 3'd0, 8'hFF, 1'b1, 3'd1, 3'd1, 4'd0};

    // Reset state, asserted at time zero.
    set_in(8'h00, 1'b0, 3'd0);
    rstn = 1'b0;
    #1;
    chk("rst_cv", 64'(cv1), 64'd0);
    chk("rst_cnt", 64'(cnt1), 64'd0);
    chk("rst_tag", 64'(tag1[0]), 64'd0);
    chk("rst_data", 64'(data1[0]), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rst_ready", 64'(ready1), 64'hFF);
    tick;

    // Mixed traffic, flush and back-to-back refill from the vector table.
    for (int n = 0; n < 13; n++) begin
      set_in(tbl[n].v, tbl[n].fl, tbl[n].t);
      #1;
      chk($sformatf("v%0d_ready", n), 64'(ready1), 64'(tbl[n].rdy));
      tick;
      chk($sformatf("v%0d_cv", n), 64'(cv1[0]), 64'(tbl[n].cv));
      chk($sformatf("v%0d_src", n), 64'(src1[0]), 64'(tbl[n].src));
      chk($sformatf("v%0d_tag", n), 64'(tag1[0]), 64'(tbl[n].tag));
      chk($sformatf("v%0d_cnt", n), 64'(cnt1), 64'(tbl[n].cnt));
      if (tbl[n].cv)
        chk($sformatf("v%0d_data", n), 64'(data1[0]), 64'(data_of(int'(tbl[n].src), tbl[n].tag)));
    end

    // Reset mid-traffic with three slots full.
    do_reset();
    set_in(8'b0100_1010, 1'b0, 3'd2);
    tick;
    set_in(8'h00, 1'b0, 3'd0);
    chk("mid_cnt3", 64'(cnt1), 64'd3);
    tick;
    chk("mid_cv_pre", 64'(cv1), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_cv", 64'(cv1), 64'd0);
    chk("mid_cnt", 64'(cnt1), 64'd0);
    chk("mid_src", 64'(src1[0]), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("mid_ready", 64'(ready1), 64'hFF);
    tick;
    chk("mid_no_cv", 64'(cv1), 64'd0);

    // Single source, uncontended latency.
    do_reset();
    set_in(8'h20, 1'b0, 3'd3);
    src_data[5] = 32'hDEAD_BEEF;
    tick;
    set_in(8'h00, 1'b0, 3'd0);
    chk("one_cv0", 64'(cv1), 64'd0);
    chk("one_cnt1", 64'(cnt1), 64'd1);
    tick;
    chk("one_cv1", 64'(cv1), 64'd1);
    chk("one_tag", 64'(tag1[0]), 64'd3);
    chk("one_data", 64'(data1[0]), 64'hDEAD_BEEF);
    chk("one_src", 64'(src1[0]), 64'd5);
    chk("one_cnt0", 64'(cnt1), 64'd0);
    tick;
    chk("one_cv_drop", 64'(cv1), 64'd0);

    // Fairness: all units continuously valid.
    do_reset();
    set_in(8'hFF, 1'b0, 3'd4);
    tick;
    chk("fair_cv0", 64'(cv1), 64'd0);
    chk("fair_cnt", 64'(cnt1), 64'd8);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("fair%0d_ready", k), 64'(ready1), 64'(8'd1 << (k % 8)));
      tick;
      chk($sformatf("fair%0d_cv", k), 64'(cv1), 64'd1);
      chk($sformatf("fair%0d_src", k), 64'(src1[0]), 64'(k % 8));
      chk($sformatf("fair%0d_cnt", k), 64'(cnt1), 64'd8);
    end

    // Flush with units 2 and 4 pending and unit 3 offering.
    do_reset();
    set_in(8'h14, 1'b0, 3'd1);
    tick;
    chk("fl_cnt2", 64'(cnt1), 64'd2);
    set_in(8'h08, 1'b1, 3'd6);
    #1;
    chk("fl_ready", 64'(ready1), 64'h00);
    tick;
    chk("fl_cv", 64'(cv1), 64'd0);
    chk("fl_cnt", 64'(cnt1), 64'd0);
    set_in(8'h00, 1'b0, 3'd0);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk($sformatf("fl_quiet%0d", k), 64'(cv1), 64'd0);
    end

    // Dual lane: bring rr_ptr to 6, then units 1, 6, 7 full.
    do_reset();
    set_in(8'h20, 1'b0, 3'd3);
    tick;
    set_in(8'h00, 1'b0, 3'd0);
    tick;
    chk("dual_pre_cv", 64'(cv2), 64'b01);
    chk("dual_pre_src", 64'(src2[0]), 64'd5);
    chk("dual_rr6", 64'(dut2.rr_ptr), 64'd6);
    set_in(8'b1100_0010, 1'b0, 3'd6);
    tick;
    set_in(8'h00, 1'b0, 3'd0);
    chk("dual_load_cv", 64'(cv2), 64'd0);
    chk("dual_ready", 64'(ready2), 64'hFD);
    tick;
    chk("dual_cv", 64'(cv2), 64'b11);
    chk("dual_lane0", 64'(src2[0]), 64'd6);
    chk("dual_lane1", 64'(src2[1]), 64'd7);
    chk("dual_data1", 64'(data2[1]), 64'(data_of(7, 3'd6)));
    chk("dual_rr0", 64'(dut2.rr_ptr), 64'd0);
    chk("dual_cnt", 64'(cnt2), 64'd1);
    tick;
    chk("dual_cv_b", 64'(cv2), 64'b01);
    chk("dual_lane0_b", 64'(src2[0]), 64'd1);
    chk("dual_lane1_hold", 64'(src2[1]), 64'd7);
    chk("dual_cnt_b", 64'(cnt2), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
